// File: rtl/reg_dump_ctrl_pkg.sv
// Shared definitions for the register dump controller.
//   state_e        : controller FSM states (2-bit encoding)
//   BYTES_PER_REG  : bytes in one register frame (index byte + 4 data bytes)
//   CNT_W          : width of the byte counter inside the serializer
//   HDR_IDX        : byte position of the index (header) byte in a frame
//   LAST_BYTE      : byte position of the final data byte in a frame
package reg_dump_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SEND   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int BYTES_PER_REG = 5;
    localparam int CNT_W         = 3;

    localparam logic [CNT_W-1:0] HDR_IDX   = 3'd0;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_REG - 1);

endpackage

// File: rtl/reg_dump_ctrl_serializer.sv
// Turns one sampled register into a 5-byte valid/ready frame:
// index byte first, then the data word least-significant byte first.
// Ports:
//   clk, rst    : clock and asynchronous active-high reset
//   load        : capture data/index frame source and restart at the header
//   send        : frame is being presented (drives tx_valid)
//   data        : register value, sampled only on load
//   index       : register index, shown in the header byte
//   tx_ready    : transmitter handshake
//   tx_data     : byte currently offered
//   tx_valid    : tx_data is valid
//   last_byte   : final byte of the frame is being transferred this cycle
module reg_dump_ctrl_serializer
    import reg_dump_ctrl_pkg::*;
#(
    parameter int IDX_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              send,
    input  logic [DATA_W-1:0] data,
    input  logic [IDX_W-1:0]  index,
    input  logic              tx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    output logic              last_byte
);

    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [7:0]        byte_sel;
    logic              xfer;

    assign xfer      = send && tx_ready;
    assign tx_valid  = send;
    assign last_byte = xfer && (byte_cnt_q == LAST_BYTE);

    // Byte counter and data snapshot: the counter only moves on a real
    // handshake, so a stalled byte is held unchanged until it is accepted.
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        data_d     = data_q;
        if (load) begin
            byte_cnt_d = HDR_IDX;
            data_d     = data;
        end else if (xfer) begin
            byte_cnt_d = (byte_cnt_q == LAST_BYTE) ? HDR_IDX : byte_cnt_q + 1'b1;
        end
    end

    // Frame byte multiplexer; tx_data idles at zero when nothing is offered.
    always_comb begin
        byte_sel = 8'h00;
        case (byte_cnt_q)
            HDR_IDX: byte_sel = {{(8-IDX_W){1'b0}}, index};
            3'd1:    byte_sel = data_q[7:0];
            3'd2:    byte_sel = data_q[15:8];
            3'd3:    byte_sel = data_q[23:16];
            3'd4:    byte_sel = data_q[31:24];
            default: byte_sel = 8'h00;
        endcase
        tx_data = send ? byte_sel : 8'h00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_q <= HDR_IDX;
            data_q     <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            data_q     <= data_d;
        end
    end

endmodule

// File: rtl/reg_dump_ctrl.sv
// Register dump master: walks the register file debug view from first_reg
// to last_reg (inclusive) and streams each register as a 5-byte frame.
// Ports:
//   clk, rst            : clock and asynchronous active-high reset
//   start, abort        : dump request (IDLE only) / synchronous cancel
//   first_reg, last_reg : dump range, latched when start is accepted
//   view, view_data     : register file debug index and its read data
//   tx_data, tx_valid   : byte stream to the transmitter
//   tx_ready            : transmitter accepts the current byte
//   busy                : dump in progress (SETTLE or SEND)
//   done                : one-cycle pulse when a dump completes normally
//   range_err           : one-cycle pulse when start had first_reg > last_reg
module reg_dump_ctrl
    import reg_dump_ctrl_pkg::*;
#(
    parameter int IDX_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [IDX_W-1:0]  first_reg,
    input  logic [IDX_W-1:0]  last_reg,
    output logic [IDX_W-1:0]  view,
    input  logic [DATA_W-1:0] view_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done,
    output logic              range_err
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] view_q, view_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic             range_err_q, range_err_d;
    logic             load;
    logic             last_byte;

    // Next-state logic. Abort overrides everything, including a start seen in
    // IDLE and a final byte completing in SEND, so it never yields done.
    // The view only advances after the last byte of a frame that is not the
    // final register, which is what keeps it from wrapping past 31.
    always_comb begin
        state_d     = state_q;
        view_d      = view_q;
        last_d      = last_q;
        range_err_d = 1'b0;
        load        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!abort && start) begin
                    if (first_reg <= last_reg) begin
                        state_d = ST_SETTLE;
                        view_d  = first_reg;
                        last_d  = last_reg;
                    end else begin
                        range_err_d = 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    load    = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (last_byte) begin
                    if (view_q == last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SETTLE;
                        view_d  = view_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, view index, latched range end and the range error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            view_q      <= '0;
            last_q      <= '0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            view_q      <= view_d;
            last_q      <= last_d;
            range_err_q <= range_err_d;
        end
    end

    assign view      = view_q;
    assign busy      = (state_q == ST_SETTLE) || (state_q == ST_SEND);
    assign done      = (state_q == ST_DONE);
    assign range_err = range_err_q;

    reg_dump_ctrl_serializer #(
        .IDX_W  (IDX_W),
        .DATA_W (DATA_W)
    ) u_serializer (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .send      (state_q == ST_SEND),
        .data      (view_data),
        .index     (view_q),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .last_byte (last_byte)
    );

endmodule
